// File: rtl/easy6502_pkg.sv
// rtl/easy6502_pkg.sv - shared constants and state encodings for the UART program loader
package easy6502_pkg;

  localparam logic [15:0] LOAD_ADDR_DEFAULT = 16'h0600;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  typedef enum logic {L_RUN, L_LOAD} ld_state_e;

endpackage

// File: rtl/uart_prog_loader_if.sv
// rtl/uart_prog_loader_if.sv - program RAM write port driven by the loader
interface uart_prog_loader_if;

  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;

  modport master (output mem_we, output mem_addr, output mem_wdata);
  modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);

endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 2-FF synchronizer plus 8N1 receive FSM with one-cycle byte/framing pulses
module uart_rx
  import easy6502_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       framing_error
);

  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);

  rx_state_e   state_q, state_d;
  logic        sync1_q, sync1_d, sync2_q, sync2_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        wait_hi_q, wait_hi_d;

  always_comb begin
    sync1_d   = rxd;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    wait_hi_d = wait_hi_q;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_STOP: begin
        // After a bad stop bit, stay here until the line returns high so a
        // long break is not mistaken for a new start bit.
        if (wait_hi_q) begin
          if (sync2_q) begin
            wait_hi_d = 1'b0;
            state_d   = RX_IDLE;
          end
        end else if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (sync2_q) begin
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d    = 1'b1;
            wait_hi_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      wait_hi_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      wait_hi_q <= wait_hi_d;
    end
  end

  assign byte_valid    = valid_q;
  assign byte_data     = shift_q;
  assign framing_error = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - serial program loader into 6502 RAM, holds CPU in reset while loading
// Optional running checksum of loaded bytes enabled by LOADER_CHECKSUM_EN.
module uart_prog_loader
  import easy6502_pkg::*;
#(
  parameter int          CLK_HZ       = 25000000,
  parameter int          BAUD         = 115200,
  parameter logic [15:0] LOAD_ADDR    = LOAD_ADDR_DEFAULT,
  parameter int          IDLE_TIMEOUT = 100000
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       rxd,
  uart_prog_loader_if.master         mem,
  output logic                       cpu_hold,
  output logic                       load_done,
  output logic [15:0]                byte_count,
  output logic                       frame_err,
  output logic                       overflow,
  output logic [7:0]                 checksum
);

  localparam int          CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam logic [31:0] TIMEOUT_M1   = 32'(IDLE_TIMEOUT - 1);

  logic       bv, rx_ferr;
  logic [7:0] bd;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk           (clk),
    .resetn        (resetn),
    .rxd           (rxd),
    .byte_valid    (bv),
    .byte_data     (bd),
    .framing_error (rx_ferr)
  );

  ld_state_e   state_q, state_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic [15:0] count_q, count_d;
  logic        ferr_q, ferr_d;
  logic        ovf_q, ovf_d;
  logic        full_q, full_d;
  logic [31:0] timer_q, timer_d;
  logic        start_load, wr_en;
  logic [15:0] next_addr;

  assign next_addr = LOAD_ADDR + count_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    hold_d     = hold_q;
    done_d     = 1'b0;
    count_d    = count_q;
    ferr_d     = ferr_q | rx_ferr;
    ovf_d      = ovf_q;
    full_d     = full_q;
    timer_d    = timer_q;
    start_load = 1'b0;
    wr_en      = 1'b0;
    case (state_q)
      L_RUN: begin
        if (bv) begin
          start_load = 1'b1;
          wr_en      = 1'b1;
          state_d    = L_LOAD;
          addr_d     = LOAD_ADDR;
          wdata_d    = bd;
          hold_d     = 1'b1;
          count_d    = 16'd1;
          ferr_d     = 1'b0;
          ovf_d      = 1'b0;
          full_d     = (LOAD_ADDR == 16'hFFFF);
          timer_d    = '0;
        end
      end
      L_LOAD: begin
        // An arriving byte takes priority over a timer expiring in the same cycle.
        if (bv) begin
          timer_d = '0;
          if (full_q) begin
            ovf_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            addr_d  = next_addr;
            wdata_d = bd;
            count_d = count_q + 16'd1;
            full_d  = (next_addr == 16'hFFFF);
          end
        end else if (timer_q == TIMEOUT_M1) begin
          done_d  = 1'b1;
          hold_d  = 1'b0;
          state_d = L_RUN;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: state_d = L_RUN;
    endcase
    we_d = wr_en;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= L_RUN;
      we_q    <= 1'b0;
      addr_q  <= LOAD_ADDR;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      count_q <= '0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
      full_q  <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      count_q <= count_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
      full_q  <= full_d;
      timer_q <= timer_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (start_load)  sum_d = bd;
    else if (wr_en)  sum_d = sum_q + bd;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sum_q <= '0;
    else         sum_q <= sum_d;
  end

  assign checksum = sum_q;
`else
  assign checksum = 8'h00;
`endif

  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign cpu_hold      = hold_q;
  assign load_done     = done_q;
  assign byte_count    = count_q;
  assign frame_err     = ferr_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - randomized self-checking bench for uart_prog_loader
module tb_uart_prog_loader;

  localparam int CLK_HZ  = 1_600_000;
  localparam int BAUD    = 100_000;
  localparam int CPB     = CLK_HZ / BAUD;
  localparam int TIMEOUT = 300;
  localparam int WAIT_MAX = 3000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic rxd = 1'b1;
  always #5 clk = ~clk;

  uart_prog_loader_if mif0();
  uart_prog_loader_if mif1();

  logic        cpu_hold0, load_done0, frame_err0, overflow0;
  logic [15:0] byte_count0;
  logic [7:0]  checksum0;
  logic        cpu_hold1, load_done1, frame_err1, overflow1;
  logic [15:0] byte_count1;
  logic [7:0]  checksum1;

  uart_prog_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .LOAD_ADDR(16'h0600), .IDLE_TIMEOUT(TIMEOUT)) dut0 (
    .clk(clk), .resetn(resetn), .rxd(rxd), .mem(mif0.master), .cpu_hold(cpu_hold0),
    .load_done(load_done0), .byte_count(byte_count0), .frame_err(frame_err0),
    .overflow(overflow0), .checksum(checksum0));

  uart_prog_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .LOAD_ADDR(16'hFFFE), .IDLE_TIMEOUT(TIMEOUT)) dut1 (
    .clk(clk), .resetn(resetn), .rxd(rxd), .mem(mif1.master), .cpu_hold(cpu_hold1),
    .load_done(load_done1), .byte_count(byte_count1), .frame_err(frame_err1),
    .overflow(overflow1), .checksum(checksum1));

  int n_checks = 0;
  int n_fail = 0;

  logic [15:0] wa0[$], wa1[$];
  logic [7:0]  wd0[$], wd1[$];
  int          done0 = 0, done1 = 0, hold_err0 = 0;
  logic        hold_at_done0 = 1'b1;

  always @(negedge clk) begin
    if (mif0.mem_we) begin
      wa0.push_back(mif0.mem_addr);
      wd0.push_back(mif0.mem_wdata);
      if (!cpu_hold0) hold_err0++;
    end
    if (mif1.mem_we) begin
      wa1.push_back(mif1.mem_addr);
      wd1.push_back(mif1.mem_wdata);
    end
    if (load_done0) begin
      done0++;
      hold_at_done0 = cpu_hold0;
    end
    if (load_done1) done1++;
  end

  // Reference model: bytes land at consecutive addresses from the base,
  // anything that would pass 0xFFFF is dropped and flagged.
  logic [7:0]  tx_q[$];
  logic [15:0] exp_a[$];
  logic [7:0]  exp_d[$];
  int          exp_cnt;
  logic        exp_ovf;
  logic [7:0]  exp_sum;

  task automatic model_expect(input int base);
    exp_a.delete();
    exp_d.delete();
    exp_cnt = 0;
    exp_ovf = 1'b0;
    exp_sum = 8'h00;
    foreach (tx_q[i]) begin
      if (base + i <= 65535) begin
        exp_a.push_back(16'(base + i));
        exp_d.push_back(tx_q[i]);
        exp_cnt++;
        exp_sum = 8'((int'(exp_sum) + int'(tx_q[i])) % 256);
      end else begin
        exp_ovf = 1'b1;
      end
    end
`ifndef LOADER_CHECKSUM_EN
    exp_sum = 8'h00;
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(negedge clk);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_ok;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic send_queue(input int gap_max);
    foreach (tx_q[i]) begin
      send_byte(tx_q[i], 1'b1);
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
    end
  endtask

  task automatic wait_done(input int which, output int waited);
    int start;
    start = which ? done1 : done0;
    waited = 0;
    while (((which ? done1 : done0) == start) && waited < WAIT_MAX) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
  endtask

  task automatic clear_mon();
    wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
    hold_err0 = 0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (mif0.mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %0h expected 0", mif0.mem_we); end
    n_checks++; if (mif0.mem_addr !== 16'h0600) begin n_fail++; $display("FAIL rst_mem_addr: got %0h expected 600", mif0.mem_addr); end
    n_checks++; if (mif0.mem_wdata !== 8'h00) begin n_fail++; $display("FAIL rst_mem_wdata: got %0h expected 0", mif0.mem_wdata); end
    n_checks++; if (cpu_hold0 !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_hold: got %0h expected 1", cpu_hold0); end
    n_checks++; if (load_done0 !== 1'b0) begin n_fail++; $display("FAIL rst_load_done: got %0h expected 0", load_done0); end
    n_checks++; if (byte_count0 !== 16'h0) begin n_fail++; $display("FAIL rst_byte_count: got %0h expected 0", byte_count0); end
    n_checks++; if ({frame_err0, overflow0} !== 2'b00) begin n_fail++; $display("FAIL rst_flags: got %0h expected 0", {frame_err0, overflow0}); end
    n_checks++; if (checksum0 !== 8'h00) begin n_fail++; $display("FAIL rst_checksum: got %0h expected 0", checksum0); end
    n_checks++; if (mif1.mem_addr !== 16'hFFFE) begin n_fail++; $display("FAIL rst_mem_addr1: got %0h expected fffe", mif1.mem_addr); end
    resetn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_program();
    int waited;
    clear_mon();
    tx_q = '{8'ha9, 8'h01, 8'h8d, 8'h00, 8'h02, 8'h4c, 8'h00, 8'h06};
    model_expect(16'h0600);
    send_queue(0);
    wait_done(0, waited);
    n_checks++; if (wa0.size() !== exp_a.size()) begin n_fail++; $display("FAIL prog_wr_count: got %0d expected %0d", wa0.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size() && i < wa0.size(); i++) begin
      n_checks++;
      if ({wa0[i], wd0[i]} !== {exp_a[i], exp_d[i]}) begin
        n_fail++; $display("FAIL prog_wr[%0d]: got %0h:%0h expected %0h:%0h", i, wa0[i], wd0[i], exp_a[i], exp_d[i]);
      end
    end
    n_checks++; if (hold_err0 !== 0) begin n_fail++; $display("FAIL prog_hold_during_load: got %0d low writes expected 0", hold_err0); end
    n_checks++; if (waited < TIMEOUT - 30 || waited > TIMEOUT + 10) begin n_fail++; $display("FAIL prog_done_latency: got %0d cycles expected about %0d", waited, TIMEOUT); end
    n_checks++; if (hold_at_done0 !== 1'b0) begin n_fail++; $display("FAIL prog_hold_at_done: got %0h expected 0", hold_at_done0); end
    n_checks++; if (byte_count0 !== 16'(exp_cnt)) begin n_fail++; $display("FAIL prog_byte_count: got %0h expected %0h", byte_count0, exp_cnt); end
    n_checks++; if (checksum0 !== exp_sum) begin n_fail++; $display("FAIL prog_checksum: got %0h expected %0h", checksum0, exp_sum); end
    n_checks++; if (cpu_hold0 !== 1'b0) begin n_fail++; $display("FAIL prog_cpu_hold: got %0h expected 0", cpu_hold0); end
  endtask

  task automatic test_glitch();
    int d0;
    clear_mon();
    d0 = done0;
    @(negedge clk) rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    n_checks++; if (wa0.size() !== 0) begin n_fail++; $display("FAIL glitch_no_write: got %0d writes expected 0", wa0.size()); end
    n_checks++; if (frame_err0 !== 1'b0) begin n_fail++; $display("FAIL glitch_frame_err: got %0h expected 0", frame_err0); end
    n_checks++; if ({done0 != d0, cpu_hold0} !== 2'b00) begin n_fail++; $display("FAIL glitch_state: got %0h expected 0", {done0 != d0, cpu_hold0}); end
  endtask

  task automatic test_frame_err();
    logic [15:0] cnt_before;
    clear_mon();
    cnt_before = byte_count0;
    send_byte(8'h55, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    n_checks++; if (wa0.size() !== 0) begin n_fail++; $display("FAIL ferr_no_write: got %0d writes expected 0", wa0.size()); end
    n_checks++; if (frame_err0 !== 1'b1) begin n_fail++; $display("FAIL ferr_flag: got %0h expected 1", frame_err0); end
    n_checks++; if (byte_count0 !== cnt_before) begin n_fail++; $display("FAIL ferr_count_held: got %0h expected %0h", byte_count0, cnt_before); end
  endtask

  task automatic test_second_program();
    int waited, d0;
    clear_mon();
    d0 = done0;
    tx_q = '{8'hEA};
    model_expect(16'h0600);
    send_queue(0);
    repeat (2 * CPB) @(negedge clk);
    n_checks++; if (cpu_hold0 !== 1'b1) begin n_fail++; $display("FAIL second_hold_rises: got %0h expected 1", cpu_hold0); end
    n_checks++; if (frame_err0 !== 1'b0) begin n_fail++; $display("FAIL second_ferr_cleared: got %0h expected 0", frame_err0); end
    wait_done(0, waited);
    n_checks++; if (wa0.size() !== 1 || wa0[0] !== 16'h0600 || wd0[0] !== 8'hEA) begin n_fail++; $display("FAIL second_write: got %0d writes expected one 600:ea", wa0.size()); end
    n_checks++; if (byte_count0 !== 16'd1) begin n_fail++; $display("FAIL second_byte_count: got %0h expected 1", byte_count0); end
    n_checks++; if (done0 - d0 !== 1) begin n_fail++; $display("FAIL second_load_done: got %0d pulses expected 1", done0 - d0); end
    n_checks++; if (hold_err0 !== 0) begin n_fail++; $display("FAIL second_hold_during_write: got %0d expected 0", hold_err0); end
  endtask

  task automatic test_random_load(input int gap_max, input string tag);
    int waited, n;
    clear_mon();
    tx_q.delete();
    n = $urandom_range(1, 6);
    for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
    model_expect(16'h0600);
    send_queue(gap_max);
    wait_done(0, waited);
    n_checks++; if (wa0.size() !== exp_a.size()) begin n_fail++; $display("FAIL %s_wr_count: got %0d expected %0d", tag, wa0.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size() && i < wa0.size(); i++) begin
      n_checks++;
      if ({wa0[i], wd0[i]} !== {exp_a[i], exp_d[i]}) begin
        n_fail++; $display("FAIL %s_wr[%0d]: got %0h:%0h expected %0h:%0h", tag, i, wa0[i], wd0[i], exp_a[i], exp_d[i]);
      end
    end
    n_checks++; if (byte_count0 !== 16'(exp_cnt)) begin n_fail++; $display("FAIL %s_byte_count: got %0h expected %0h", tag, byte_count0, exp_cnt); end
    n_checks++; if (checksum0 !== exp_sum) begin n_fail++; $display("FAIL %s_checksum: got %0h expected %0h", tag, checksum0, exp_sum); end
    n_checks++; if (cpu_hold0 !== 1'b0) begin n_fail++; $display("FAIL %s_cpu_hold: got %0h expected 0", tag, cpu_hold0); end
  endtask

  task automatic test_reset_mid_byte();
    int waited;
    send_byte(8'h11, 1'b1);
    @(negedge clk) rxd = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    resetn = 1'b0;
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if ({mif0.mem_we, mif0.mem_addr, mif0.mem_wdata} !== {1'b0, 16'h0600, 8'h00}) begin n_fail++; $display("FAIL midrst_mem: got %0h expected %0h", {mif0.mem_we, mif0.mem_addr, mif0.mem_wdata}, {1'b0, 16'h0600, 8'h00}); end
    n_checks++; if ({cpu_hold0, load_done0, byte_count0} !== {1'b1, 1'b0, 16'h0}) begin n_fail++; $display("FAIL midrst_ctrl: got %0h expected %0h", {cpu_hold0, load_done0, byte_count0}, {1'b1, 1'b0, 16'h0}); end
    n_checks++; if ({frame_err0, overflow0, checksum0} !== 10'h0) begin n_fail++; $display("FAIL midrst_flags: got %0h expected 0", {frame_err0, overflow0, checksum0}); end
    resetn = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    clear_mon();
    send_byte(8'h3C, 1'b1);
    wait_done(0, waited);
    n_checks++; if (wa0.size() !== 1 || wa0[0] !== 16'h0600 || wd0[0] !== 8'h3C) begin n_fail++; $display("FAIL midrst_next_write: got %0d writes expected one 600:3c", wa0.size()); end
    n_checks++; if (byte_count0 !== 16'd1) begin n_fail++; $display("FAIL midrst_byte_count: got %0h expected 1", byte_count0); end
  endtask

  task automatic test_overflow();
    int waited;
    clear_mon();
    tx_q.delete();
    for (int i = 0; i < 3; i++) tx_q.push_back(8'($urandom));
    model_expect(16'hFFFE);
    send_queue(0);
    wait_done(1, waited);
    n_checks++; if (wa1.size() !== exp_a.size()) begin n_fail++; $display("FAIL ovf_wr_count: got %0d expected %0d", wa1.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size() && i < wa1.size(); i++) begin
      n_checks++;
      if ({wa1[i], wd1[i]} !== {exp_a[i], exp_d[i]}) begin
        n_fail++; $display("FAIL ovf_wr[%0d]: got %0h:%0h expected %0h:%0h", i, wa1[i], wd1[i], exp_a[i], exp_d[i]);
      end
    end
    n_checks++; if (overflow1 !== exp_ovf) begin n_fail++; $display("FAIL ovf_flag: got %0h expected %0h", overflow1, exp_ovf); end
    n_checks++; if (byte_count1 !== 16'(exp_cnt)) begin n_fail++; $display("FAIL ovf_byte_count: got %0h expected %0h", byte_count1, exp_cnt); end
    n_checks++; if (checksum1 !== exp_sum) begin n_fail++; $display("FAIL ovf_checksum: got %0h expected %0h", checksum1, exp_sum); end
    n_checks++; if (overflow0 !== 1'b0) begin n_fail++; $display("FAIL ovf_base_clear: got %0h expected 0", overflow0); end
  endtask

  initial begin
    test_reset();
    test_program();
    test_glitch();
    test_frame_err();
    test_second_program();
    test_random_load(TIMEOUT / 3, "rand");
    test_random_load(0, "b2b");
    test_reset_mid_byte();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Receives 8N1 serial bytes on the host UART line and writes them sequentially into the 6502 program RAM, starting at LOAD_ADDR (0x0600).
- Holds the CPU in reset while a program is arriving.
- Releases the CPU after the line has been idle for a timeout.
- Sits between the board serial_rxd pin and the RAM write port / CPU reset inside top_easy6502.

Parameters:
- CLK_HZ, 25000000, system clock frequency in Hz.
- BAUD, 115200, line rate. CLKS_PER_BIT = CLK_HZ/BAUD, integer-truncated, so 217 at the defaults.
- LOAD_ADDR, 16'h0600, address of the first program byte.
- IDLE_TIMEOUT, 100000, clock cycles of no received byte that end a load (4 ms at 25 MHz).

Ports:
- clk  in  1  system clock (CLK_25M domain).
- resetn  in  1  asynchronous active-low reset.
- rxd  in  1  raw serial input, idle high, asynchronous to clk.
- mem_we  out  1  one-cycle RAM write strobe.
- mem_addr  out  16  RAM write address.
- mem_wdata  out  8  RAM write data.
- cpu_hold  out  1  high = keep CPU in reset.
- load_done  out  1  one-cycle pulse when a load completes.
- byte_count  out  16  number of bytes written by the last or current load.
- frame_err  out  1  sticky bad-stop-bit flag; cleared at the start of each load.
- overflow  out  1  sticky flag: bytes dropped past 0xFFFF; cleared at the start of each load.
- checksum  out  8  see Optional Feature.

Behaviour:
- Reset values: mem_we=0, mem_addr=LOAD_ADDR, mem_wdata=0, cpu_hold=1 (CPU stays held until the first program is loaded), load_done=0, byte_count=0, frame_err=0, overflow=0, checksum=0.
- Reset asserted mid-byte or mid-load aborts everything and restores these values.
- rxd passes through a 2-FF synchronizer, reset value 1. All decisions use the synchronized bit.
- RX FSM:
  - RX_IDLE: a synchronized 0 moves to RX_START and clears the bit counter.
  - RX_START: wait CLKS_PER_BIT/2 cycles, then sample. Sample 0 -> RX_DATA. Sample 1 -> glitch, back to RX_IDLE with no byte.
  - RX_DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, shifted into the data register.
  - RX_STOP: sample after CLKS_PER_BIT cycles. Sample 1 -> byte_valid pulse for one cycle. Sample 0 -> set frame_err, drop the byte, wait for rxd high, then go to RX_IDLE.
- Loader FSM:
  - L_RUN, reset state, cpu_hold=1 until the first load completes:
    - a byte_valid starts a new load.
    - On starting: mem_addr=LOAD_ADDR; byte_count, frame_err, overflow and checksum clear; cpu_hold=1; the byte is written.
    - The next state is L_LOAD.
  - L_LOAD, on each byte_valid:
    - mem_we=1 the following cycle with mem_addr = LOAD_ADDR + byte_count and mem_wdata = byte.
    - Then byte_count increments and the idle timer restarts.
    - Write latency: mem_we is high exactly one cycle after the byte_valid cycle.
    - Address pointer at 0xFFFF already written: further bytes are dropped and overflow=1. Writes never wrap to 0x0000.
  - Idle timer reaches IDLE_TIMEOUT with no byte_valid:
    - load_done pulses for one cycle.
    - cpu_hold falls the same cycle.
    - State returns to L_RUN.
    - byte_count and the flags hold their values.
  - byte_valid in the same cycle as the timer expiring: the byte wins. It is written, the timer restarts and there is no load_done.
  - A frame error does not restart the idle timer.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined: checksum = modulo-256 sum of all bytes written in the current or last load, updated in the same cycle as mem_we.
- Undefined: checksum is tied to 8'h00, and the adder and register are absent.

Decomposition:
- Package easy6502_pkg holds:
  - constant LOAD_ADDR_DEFAULT = 16'h0600;
  - RX state enum {RX_IDLE, RX_START, RX_DATA, RX_STOP};
  - loader state enum {L_RUN, L_LOAD}.
- Sub-module uart_rx (synchronizer plus RX FSM) outputs byte_valid, byte_data and framing_error. uart_prog_loader instantiates it and adds the loader FSM.

Test Plan:
- Send bytes a9 01 8d 00 02 4c 00 06 at 8681 ns per bit -> eight mem_we pulses writing 0x0600..0x0607 with those values; cpu_hold stays 1 throughout; load_done pulses about 4 ms after the last stop bit; then byte_count=8, checksum=0x8B (with LOADER_CHECKSUM_EN), cpu_hold=0.
- 2 µs low glitch on rxd while idle -> no mem_we, frame_err=0.
- Byte 0x55 with its stop bit forced low -> no write, frame_err=1. The next valid load clears frame_err.
- Second program 0xEA after the first load completes -> cpu_hold rises, write 0xEA to 0x0600, byte_count=1, load_done after the timeout.
- Reset pulse mid-byte during a load -> all outputs return to reset values; the next full byte is written to 0x0600.
- LOAD_ADDR=16'hFFFE with 3 bytes -> writes to 0xFFFE and 0xFFFF only, overflow=1, byte_count=2.
